// File: rtl/order_book_pkg.sv
// rtl/order_book_pkg.sv - request codes, message field offsets, FSM states and command record
package order_book_pkg;

  localparam logic [7:0] REQ_ADD      = 8'h53;
  localparam logic [7:0] REQ_DELETE   = 8'h44;
  localparam logic [7:0] REQ_DECREASE = 8'h45;

  // MSB of each field inside the ingress message
  localparam int REQ_MSB  = 319;
  localparam int OID_MSB  = 247;
  localparam int SID_MSB  = 183;
  localparam int SIDE_MSB = 151;
  localparam int QTY_MSB  = 143;
  localparam int PX_MSB   = 111;

  localparam int MAX_STOCKS = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    DISPATCH = 2'd2
  } dispatch_state_e;

  typedef struct packed {
    logic [31:0]               order_id;
    logic [31:0]               quantity;
    logic [63:0]               price;
    logic [7:0]                side;
    logic [3*MAX_STOCKS-1:0]   stock_activate;
  } command_t;

  // {add, delete, decrease}; all-zero marks an unknown request
  function automatic logic [2:0] req_code(input logic [7:0] req);
    case (req)
      REQ_ADD:      req_code = 3'b100;
      REQ_DELETE:   req_code = 3'b010;
      REQ_DECREASE: req_code = 3'b001;
      default:      req_code = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/order_dispatcher_stock_id_lookup.sv
// rtl/order_dispatcher_stock_id_lookup.sv - maps a stock_id onto a book index on a BASE + i*STEP grid
module stock_id_lookup #(
  parameter int          NUM_STOCKS = 4,
  parameter logic [31:0] BASE       = 32'h10,
  parameter logic [31:0] STEP       = 32'h10,
  parameter int          IDX_W      = 2
) (
  input  logic [31:0]      stock_id,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  logic [31:0] offset;
  logic [31:0] quot;

  always_comb begin
    offset = stock_id - BASE;
    quot   = offset / STEP;
    hit    = (stock_id >= BASE) && ((offset % STEP) == 32'd0) && (quot < 32'(NUM_STOCKS));
    index  = quot[IDX_W-1:0];
  end

endmodule

// File: rtl/order_dispatcher.sv
// rtl/order_dispatcher.sv - pops order messages and dispatches one-hot commands to NUM_STOCKS books
// Optional saturating statistics counters under ORDER_DISPATCH_STATS_EN.
module order_dispatcher
  import order_book_pkg::*;
#(
  parameter int          NUM_STOCKS     = 4,
  parameter int          MSG_W          = 320,
  parameter logic [31:0] STOCK_ID_BASE  = 32'h10,
  parameter logic [31:0] STOCK_ID_STEP  = 32'h10,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    buf_not_empty,
  input  logic [MSG_W-1:0]        buf_data,
  output logic                    buf_pop,
  input  logic [NUM_STOCKS-1:0]   stock_ready,
  output logic                    valid,
  output logic [3*NUM_STOCKS-1:0] stock_activate,
  output logic [31:0]             out_order_id,
  output logic [31:0]             out_quantity,
  output logic [63:0]             out_price,
  output logic [7:0]              out_side,
  output logic [1:0]              current_state,
  output logic                    err_unknown,
  output logic                    err_timeout
`ifdef ORDER_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]        dispatch_count,
  output logic [CNT_W-1:0]        drop_count
`endif
);

  localparam int          IDX_W    = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  dispatch_state_e  state, state_next;
  logic [MSG_W-1:0] msg;
  logic [31:0]      tmo_cnt;
  logic [IDX_W-1:0] lk_index, target;
  logic             hit;
  logic [2:0]       code;
  command_t         cmd, cmd_next;
  logic             load_cmd, drop, ack, expire;
  logic             unused_bits;

  assign code = req_code(msg[REQ_MSB -: 8]);

  stock_id_lookup #(
    .NUM_STOCKS (NUM_STOCKS),
    .BASE       (STOCK_ID_BASE),
    .STEP       (STOCK_ID_STEP),
    .IDX_W      (IDX_W)
  ) u_lookup (
    .stock_id (msg[SID_MSB -: 32]),
    .hit      (hit),
    .index    (lk_index)
  );

  always_comb begin
    cmd_next.order_id       = msg[OID_MSB -: 32];
    cmd_next.quantity       = msg[QTY_MSB -: 32];
    cmd_next.price          = msg[PX_MSB -: 64];
    cmd_next.side           = msg[SIDE_MSB -: 8];
    // book 0 occupies the most significant triple
    cmd_next.stock_activate = {{(3*MAX_STOCKS-3){1'b0}}, code}
                              << (3 * (NUM_STOCKS - 1 - int'(lk_index)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    buf_pop    = 1'b0;
    load_cmd   = 1'b0;
    drop       = 1'b0;
    ack        = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (buf_not_empty && !reset) begin
          buf_pop    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (hit && (code != 3'b000)) begin
          load_cmd   = 1'b1;
          state_next = DISPATCH;
        end else begin
          drop       = 1'b1;
          state_next = IDLE;
        end
      end
      DISPATCH: begin
        // an ack on the timeout edge still counts as a completed dispatch
        if (valid && stock_ready[target]) begin
          ack        = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg         <= '0;
      cmd         <= '0;
      valid       <= 1'b0;
      target      <= '0;
      tmo_cnt     <= '0;
      err_unknown <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_unknown <= drop;
      err_timeout <= expire;
      if (buf_pop) msg <= buf_data;
      if (load_cmd) begin
        cmd     <= cmd_next;
        valid   <= 1'b1;
        target  <= lk_index;
        tmo_cnt <= '0;
      end else if (ack || expire) begin
        cmd    <= '0;
        valid  <= 1'b0;
        target <= '0;
      end else if (state == DISPATCH) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

  assign stock_activate = cmd.stock_activate[3*NUM_STOCKS-1:0];
  assign out_order_id   = cmd.order_id;
  assign out_quantity   = cmd.quantity;
  assign out_price      = cmd.price;
  assign out_side       = cmd.side;
  assign current_state  = state;
  assign unused_bits    = ^{msg, cmd.stock_activate};

`ifdef ORDER_DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dispatch_count <= '0;
      drop_count     <= '0;
    end else begin
      if (ack && (dispatch_count != {CNT_W{1'b1}}))
        dispatch_count <= dispatch_count + 1'b1;
      if ((drop || expire) && (drop_count != {CNT_W{1'b1}}))
        drop_count <= drop_count + 1'b1;
    end
  end
`else
  localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_order_dispatcher.sv
// tb/tb_order_dispatcher.sv - directed and randomized checks of order_dispatcher against a message-level model
module tb_order_dispatcher;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           buf_not_empty;
  logic [319:0]   buf_data;
  logic           buf_pop;
  logic [N-1:0]   stock_ready;
  logic           valid;
  logic [3*N-1:0] stock_activate;
  logic [31:0]    out_order_id, out_quantity;
  logic [63:0]    out_price;
  logic [7:0]     out_side;
  logic [1:0]     current_state;
  logic           err_unknown, err_timeout;
`ifdef ORDER_DISPATCH_STATS_EN
  logic [15:0]    dispatch_count, drop_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_disp    = 0;
  int exp_drop    = 0;

  always #5 clk = ~clk;

  order_dispatcher #(
    .NUM_STOCKS     (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .buf_not_empty  (buf_not_empty),
    .buf_data       (buf_data),
    .buf_pop        (buf_pop),
    .stock_ready    (stock_ready),
    .valid          (valid),
    .stock_activate (stock_activate),
    .out_order_id   (out_order_id),
    .out_quantity   (out_quantity),
    .out_price      (out_price),
    .out_side       (out_side),
    .current_state  (current_state),
    .err_unknown    (err_unknown),
    .err_timeout    (err_timeout)
`ifdef ORDER_DISPATCH_STATS_EN
    ,
    .dispatch_count (dispatch_count),
    .drop_count     (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef ORDER_DISPATCH_STATS_EN
    check({tag, ".dispatch_count"}, 64'(dispatch_count), 64'(exp_disp));
    check({tag, ".drop_count"}, 64'(drop_count), 64'(exp_drop));
`endif
  endtask

  function automatic logic [319:0] make_msg(input logic [7:0] req, input logic [31:0] oid,
                                            input logic [31:0] sid, input logic [7:0] side,
                                            input logic [31:0] qty, input logic [63:0] px);
    logic [319:0] m;
    for (int w = 0; w < 10; w++) m[w*32 +: 32] = $urandom();
    m[319:312] = req;
    m[247:216] = oid;
    m[183:152] = sid;
    m[151:144] = side;
    m[143:112] = qty;
    m[111:48]  = px;
    return m;
  endfunction

  // book i listens on stock_id 0x10 + 0x10*i; -1 when nobody does
  function automatic int book_of(input logic [31:0] sid);
    for (int i = 0; i < N; i++)
      if (sid == 32'(16 + 16 * i)) return i;
    return -1;
  endfunction

  function automatic logic [2:0] cmd_of(input logic [7:0] req);
    if (req == 8'h53) return 3'b100;
    if (req == 8'h44) return 3'b010;
    if (req == 8'h45) return 3'b001;
    return 3'b000;
  endfunction

  // Called at a negedge with the DUT idle; ready_at = DISPATCH cycle in which the target acks (>= TMO: never)
  task automatic run_msg(input string tag, input logic [319:0] m, input int ready_at);
    int          book;
    logic [2:0]  c;
    logic [11:0] exp_act;
    logic [N-1:0] tgt;
    bit          done;
    book    = book_of(m[183:152]);
    c       = cmd_of(m[319:312]);
    exp_act = '0;
    tgt     = '0;
    if (book >= 0 && c != 3'b000) begin
      exp_act[3*(N-book)-1 -: 3] = c;
      tgt = N'(1 << book);
    end
    buf_data      = m;
    buf_not_empty = 1'b1;
    stock_ready   = '0;
    #1 check({tag, ".pop"}, 64'(buf_pop), 64'd1);
    @(negedge clk);
    buf_not_empty = 1'b0;
    buf_data      = make_msg(8'h00, 0, 0, 0, 0, 0);
    check({tag, ".decode_pop"}, 64'(buf_pop), 64'd0);
    check({tag, ".decode_valid"}, 64'(valid), 64'd0);
    @(negedge clk);
    if (exp_act == '0) begin
      exp_drop++;
      check({tag, ".err_unknown"}, 64'(err_unknown), 64'd1);
      check({tag, ".drop_valid"}, 64'(valid), 64'd0);
      check({tag, ".drop_act"}, 64'(stock_activate), 64'd0);
      @(negedge clk);
      check({tag, ".err_unknown_end"}, 64'(err_unknown), 64'd0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < TMO && !done; k++) begin
        check({tag, ".valid"}, 64'(valid), 64'd1);
        check({tag, ".act"}, 64'(stock_activate), 64'(exp_act));
        check({tag, ".oid"}, 64'(out_order_id), 64'(m[247:216]));
        check({tag, ".qty"}, 64'(out_quantity), 64'(m[143:112]));
        check({tag, ".px"}, out_price, m[111:48]);
        check({tag, ".side"}, 64'(out_side), 64'(m[151:144]));
        stock_ready = N'($urandom_range(0, (1 << N) - 1)) & ~tgt;
        if (k >= ready_at) stock_ready = stock_ready | tgt;
        @(negedge clk);
        if (k >= ready_at) begin
          done = 1'b1;
          exp_disp++;
          check({tag, ".ack_valid"}, 64'(valid), 64'd0);
          check({tag, ".ack_no_tmo"}, 64'(err_timeout), 64'd0);
          check({tag, ".ack_act"}, 64'(stock_activate), 64'd0);
          check({tag, ".ack_px"}, out_price, 64'd0);
        end else if (k == TMO - 1) begin
          exp_drop++;
          check({tag, ".err_timeout"}, 64'(err_timeout), 64'd1);
          check({tag, ".tmo_valid"}, 64'(valid), 64'd0);
        end
      end
      stock_ready = '0;
      check({tag, ".idle"}, 64'(current_state), 64'd0);
      @(negedge clk);
      check({tag, ".err_timeout_end"}, 64'(err_timeout), 64'd0);
    end
    check_stats(tag);
  endtask

  initial begin
    logic [319:0] m;
    int           pops[$];
    logic [7:0]   req;
    logic [31:0]  sid;

    reset         = 1'b1;
    buf_not_empty = 1'b0;
    buf_data      = '0;
    stock_ready   = '0;
    #1;
    check("reset.valid", 64'(valid), 64'd0);
    check("reset.act", 64'(stock_activate), 64'd0);
    check("reset.oid", 64'(out_order_id), 64'd0);
    check("reset.state", 64'(current_state), 64'd0);
    check("reset.errs", 64'({err_unknown, err_timeout}), 64'd0);
    check_stats("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_msg("add_sid20", make_msg(8'h53, 32'd7, 32'h20, 8'h01, 32'd100, 64'd5000), 3);
    run_msg("dec_sid40", make_msg(8'h45, 32'd9, 32'h40, 8'h02, 32'd55, 64'd1234), 0);
    run_msg("bad_sid50", make_msg(8'h53, 32'd1, 32'h50, 8'h01, 32'd1, 64'd1), 0);
    run_msg("bad_req41", make_msg(8'h41, 32'd2, 32'h10, 8'h01, 32'd2, 64'd2), 0);
    run_msg("del_sid10", make_msg(8'h44, 32'd3, 32'h10, 8'h02, 32'd3, 64'd3), 1);
    run_msg("timeout", make_msg(8'h53, 32'd4, 32'h30, 8'h01, 32'd4, 64'd4), 100);
    run_msg("ack_at_tmo", make_msg(8'h44, 32'd5, 32'h20, 8'h01, 32'd5, 64'd5), TMO - 1);

    // back-to-back messages with every book acking immediately
    buf_data      = make_msg(8'h53, 32'd11, 32'h30, 8'h01, 32'd11, 64'd11);
    buf_not_empty = 1'b1;
    stock_ready   = '1;
    for (int c = 0; c < 10; c++) begin
      #1 if (buf_pop === 1'b1) pops.push_back(c);
      @(negedge clk);
    end
    buf_not_empty = 1'b0;
    repeat (3) @(negedge clk);
    stock_ready = '0;
    exp_disp += 4;
    check("b2b.pop_count", 64'(pops.size()), 64'd4);
    for (int i = 0; i < pops.size(); i++)
      check("b2b.pop_cycle", 64'(pops[i]), 64'(3 * i));
    check("b2b.idle", 64'(current_state), 64'd0);
    check_stats("b2b");

    // reset while a command is outstanding
    buf_data      = make_msg(8'h53, 32'd21, 32'h20, 8'h01, 32'd21, 64'd21);
    buf_not_empty = 1'b1;
    @(negedge clk);
    buf_not_empty = 1'b0;
    @(negedge clk);
    check("rst.pre_valid", 64'(valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.act", 64'(stock_activate), 64'd0);
    check("rst.oid", 64'(out_order_id), 64'd0);
    check("rst.px", out_price, 64'd0);
    check("rst.state", 64'(current_state), 64'd0);
    buf_not_empty = 1'b1;
    #1 check("rst.no_pop", 64'(buf_pop), 64'd0);
    @(negedge clk);
    check("rst.no_pop_held", 64'(buf_pop), 64'd0);
    exp_disp = 0;
    exp_drop = 0;
    buf_not_empty = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst.quiet", 64'({valid, err_unknown, err_timeout}), 64'd0);
    end
    check_stats("rst");
    run_msg("post_rst", make_msg(8'h45, 32'd22, 32'h40, 8'h02, 32'd22, 64'd22), 2);

    for (int r = 0; r < 25; r++) begin
      case ($urandom_range(0, 4))
        0:       req = 8'h53;
        1:       req = 8'h44;
        2:       req = 8'h45;
        3:       req = 8'h41;
        default: req = 8'($urandom());
      endcase
      case ($urandom_range(0, 5))
        0, 1, 2: sid = 32'h10 + 32'h10 * $urandom_range(0, N - 1);
        3:       sid = 32'h50;
        4:       sid = 32'h18;
        default: sid = $urandom();
      endcase
      m = make_msg(req, $urandom(), sid, 8'($urandom()), $urandom(), {$urandom(), $urandom()});
      run_msg("random", m, $urandom_range(0, TMO + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
